// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for both pointer stages of the asynchronous FIFO.
//   DEF_PTRWIDTH : default address width (FIFO depth = 2**DEF_PTRWIDTH)
//   PTR_MAXW     : widest pointer the conversion helpers handle
//   bin2gray     : binary -> reflected Gray code
//   gray2bin     : reflected Gray code -> binary
// The helpers work on PTR_MAXW-bit values, so they serve any pointer width
// up to PTR_MAXW. Callers zero-extend a narrower pointer on the way in and
// size-cast the result back down. Leading zeros convert to leading zeros in
// both directions, so the low bits of the result are exact.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_PTRWIDTH = 3;
  localparam int PTR_MAXW     = 16;

  typedef logic [PTR_MAXW-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position.
  // The loop runs MSB first and carries that running XOR downwards.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[PTR_MAXW-1] = gray[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync2ff.sv
// ---------------------------------------------------------------------------
// ptr_sync2ff
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// The read side uses it for the write pointer, and the write side uses it
// for the read pointer.
// Parameters:
//   WIDTH   : pointer width in bits
// Ports:
//   clk_i   : destination-domain clock
//   reset_i : synchronous, active-high reset that clears both stages
//   d_i     : pointer from the source domain (asynchronous to clk_i)
//   q_o     : synchronised pointer, two clk_i edges behind d_i
// ---------------------------------------------------------------------------
module ptr_sync2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable. The second stage gives it a full cycle to
  // settle. Only a single bit of a Gray pointer changes per step, so a late
  // capture yields either the old or the new value, never a mix.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rdptr_handler.sv
// ---------------------------------------------------------------------------
// rdptr_handler
// Read-side pointer stage of the asynchronous FIFO. It brings the write
// domain's Gray pointer across into rclk. It keeps the binary read pointer,
// which is the memory read address, and the Gray read pointer, which goes to
// the write domain. It produces registered empty, almost_empty and occupancy
// outputs.
// Parameters:
//   PTRWIDTH     : address width; pointers are PTRWIDTH+1 bits
//   AE_THRESH    : almost_empty is high while occupancy <= AE_THRESH
// Ports:
//   rclk         : read clock
//   rd_reset     : synchronous, active-high reset
//   r_en         : read request (ignored while empty)
//   g_wrptr      : Gray write pointer from the write domain (async)
//   b_rdptr      : binary read pointer (low PTRWIDTH bits = read address)
//   g_rdptr      : registered Gray read pointer for the write domain
//   empty        : registered empty flag
//   almost_empty : registered almost-empty flag
//   rd_count     : registered occupancy, 0 .. 2**PTRWIDTH
//   underflow    : sticky flag for a read attempted while empty
// Configuration macro:
//   RDPTR_UNDERFLOW_EN : when defined, underflow detection is built in.
//                        When undefined, underflow is tied low.
// ---------------------------------------------------------------------------
module rdptr_handler
  import fifo_pkg::*;
#(
  parameter int PTRWIDTH  = DEF_PTRWIDTH,
  parameter int AE_THRESH = 1
) (
  input  logic              rclk,
  input  logic              rd_reset,
  input  logic              r_en,
  input  logic [PTRWIDTH:0] g_wrptr,
  output logic [PTRWIDTH:0] b_rdptr,
  output logic [PTRWIDTH:0] g_rdptr,
  output logic              empty,
  output logic              almost_empty,
  output logic [PTRWIDTH:0] rd_count,
  output logic              underflow
);

  localparam int                PW       = PTRWIDTH + 1;
  localparam logic [PTRWIDTH:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PTRWIDTH:0] g_wrptr_sync;
  logic [PTRWIDTH:0] b_wrptr_sync;

  logic [PTRWIDTH:0] b_rdptr_q, b_rdptr_d;
  logic [PTRWIDTH:0] g_rdptr_q, g_rdptr_d;
  logic [PTRWIDTH:0] rd_count_q, rd_count_d;
  logic              empty_q, empty_d;
  logic              almost_empty_q, almost_empty_d;
  logic              rd_accept;

  ptr_sync2ff #(
    .WIDTH  (PW)
  ) u_wrptr_sync (
    .clk_i  (rclk),
    .reset_i(rd_reset),
    .d_i    (g_wrptr),
    .q_o    (g_wrptr_sync)
  );

  assign b_wrptr_sync = PW'(gray2bin(PTR_MAXW'(g_wrptr_sync)));

  // The next-state values are computed from the pointer after this edge's
  // read, so the final read sets empty on the same edge. Back-to-back reads
  // therefore stop without overrunning. Occupancy relies on modulo
  // 2**(PTRWIDTH+1) subtraction: the extra MSB separates full from empty.
  always_comb begin
    rd_accept      = r_en && !empty_q;
    b_rdptr_d      = b_rdptr_q;
    if (rd_accept) begin
      b_rdptr_d    = b_rdptr_q + 1'b1;
    end
    g_rdptr_d      = PW'(bin2gray(PTR_MAXW'(b_rdptr_d)));
    empty_d        = (g_rdptr_d == g_wrptr_sync);
    rd_count_d     = b_wrptr_sync - b_rdptr_d;
    almost_empty_d = (rd_count_d <= AE_LIMIT);
  end

  // All outputs are flop outputs. g_rdptr in particular must be glitch-free
  // because the write domain samples it asynchronously.
  always_ff @(posedge rclk) begin
    if (rd_reset) begin
      b_rdptr_q      <= '0;
      g_rdptr_q      <= '0;
      rd_count_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      b_rdptr_q      <= b_rdptr_d;
      g_rdptr_q      <= g_rdptr_d;
      rd_count_q     <= rd_count_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign b_rdptr      = b_rdptr_q;
  assign g_rdptr      = g_rdptr_q;
  assign rd_count     = rd_count_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;

`ifdef RDPTR_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  // Once a read is attempted against an empty FIFO, the flag stays set until
  // reset so that software can see the error after the fact.
  always_comb begin
    underflow_d = underflow_q | (r_en & empty_q);
  end

  always_ff @(posedge rclk) begin
    if (rd_reset) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_rdptr_handler.sv
// ---------------------------------------------------------------------------
// tb_rdptr_handler
// Bench for the read-pointer stage with PTRWIDTH=3 and AE_THRESH=1.
// The reference model tracks total reads and the write count that the read
// domain can see. The write count reaches that view two edges late. The
// model derives the expected pointers and flags from those counts. Expected
// results queue up per clock edge, and a separate monitor checks them
// against the DUT outputs.
// Define RDPTR_UNDERFLOW_EN for both the DUT and this bench to expect the
// sticky underflow flag.
// ---------------------------------------------------------------------------
module tb_rdptr_handler;

  localparam int PTRWIDTH = 3;
  localparam int AE_THRESH = 1;
  localparam int DEPTH = 1 << PTRWIDTH;
  localparam int MODV = 2 * DEPTH;

  typedef struct {
    int  bPtr;
    int  gPtr;
    bit  empty;
    bit  almostEmpty;
    int  count;
    bit  underflow;
  } expect_t;

  logic              rclk;
  logic              rd_reset;
  logic              r_en;
  logic [PTRWIDTH:0] g_wrptr;
  logic [PTRWIDTH:0] b_rdptr;
  logic [PTRWIDTH:0] g_rdptr;
  logic              empty;
  logic              almost_empty;
  logic [PTRWIDTH:0] rd_count;
  logic              underflow;

  expect_t expQ[$];
  int      errors = 0;
  int      checks = 0;

  // Model state: total writes issued, total reads accepted, the two-stage
  // view of the write count, and the model's empty and underflow flags.
  int wrTotal = 0;
  int rdTotal = 0;
  int seen1   = 0;
  int seen2   = 0;
  bit mEmpty  = 1'b1;
  bit mUnder  = 1'b0;

  rdptr_handler #(
    .PTRWIDTH    (PTRWIDTH),
    .AE_THRESH   (AE_THRESH)
  ) dut (
    .rclk        (rclk),
    .rd_reset    (rd_reset),
    .r_en        (r_en),
    .g_wrptr     (g_wrptr),
    .b_rdptr     (b_rdptr),
    .g_rdptr     (g_rdptr),
    .empty       (empty),
    .almost_empty(almost_empty),
    .rd_count    (rd_count),
    .underflow   (underflow)
  );

  // Free-running read clock.
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  function automatic int modPtr(input int v);
    return ((v % MODV) + MODV) % MODV;
  endfunction

  function automatic int toGray(input int v);
    int b;
    b = modPtr(v);
    return b ^ (b >> 1);
  endfunction

  // Compares one observed value with the expected one and records the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs at the falling edge. Advances the model by
  // the rising edge that follows and queues the expected register state.
  task automatic applyStimulus(input bit rst, input bit ren);
    expect_t e;
    int      occ;
    bit      underHit;
    @(negedge rclk);
    rd_reset = rst;
    r_en     = ren;
    g_wrptr  = (PTRWIDTH+1)'(toGray(wrTotal));
    if (rst) begin
      rdTotal = 0;
      seen1   = 0;
      seen2   = 0;
      mEmpty  = 1'b1;
      mUnder  = 1'b0;
      occ     = 0;
    end else begin
      underHit = ren && mEmpty;
      if (ren && !mEmpty) rdTotal++;
      occ    = modPtr(seen2 - rdTotal);
      mEmpty = (occ == 0);
      seen2  = seen1;
      seen1  = modPtr(wrTotal);
`ifdef RDPTR_UNDERFLOW_EN
      if (underHit) mUnder = 1'b1;
`else
      if (underHit) mUnder = 1'b0;
`endif
    end
    e.bPtr        = modPtr(rdTotal);
    e.gPtr        = toGray(rdTotal);
    e.empty       = mEmpty;
    e.almostEmpty = (occ <= AE_THRESH);
    e.count       = occ;
    e.underflow   = mUnder;
    expQ.push_back(e);
  endtask

  // Monitor: after every rising edge, compares the DUT outputs with the
  // expectation the stimulus queued for that edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge rclk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("b_rdptr",      32'(b_rdptr),      e.bPtr);
        checkOutput("g_rdptr",      32'(g_rdptr),      e.gPtr);
        checkOutput("empty",        32'(empty),        int'(e.empty));
        checkOutput("almost_empty", 32'(almost_empty), int'(e.almostEmpty));
        checkOutput("rd_count",     32'(rd_count),     e.count);
        checkOutput("underflow",    32'(underflow),    int'(e.underflow));
      end
    end
  end

  // Directed scenarios first, then a randomized phase with throttled writes.
  initial begin
    rd_reset = 1'b1;
    r_en     = 1'b0;
    g_wrptr  = '0;

    $display("[TB] reset");
    repeat (2) applyStimulus(1'b1, 1'b0);

    $display("[TB] single entry");
    wrTotal = 1;
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] full drain");
    applyStimulus(1'b1, 1'b0);
    wrTotal = 8;
    repeat (3) applyStimulus(1'b0, 1'b0);
    repeat (9) applyStimulus(1'b0, 1'b1);

    $display("[TB] wrap-around");
    for (int i = 0; i < 8; i++) begin
      wrTotal++;
      applyStimulus(1'b0, 1'b1);
    end
    repeat (12) applyStimulus(1'b0, 1'b1);

    $display("[TB] underflow");
    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0);

    $display("[TB] mid-operation reset");
    applyStimulus(1'b1, 1'b0);
    wrTotal = 24;
    repeat (3) applyStimulus(1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && modPtr(wrTotal - rdTotal) < DEPTH) begin
        wrTotal++;
      end
      applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    end
    repeat (12) applyStimulus(1'b0, 1'b1);

    repeat (2) @(negedge rclk);
    checkOutput("queue_drained", 32'(expQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
